// File: rtl/pixel_pair_packer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pixel_pair_packer_pkg -- shared camera-path types and default widths
// Rev 1.0
// ---------------------------------------------------------------------------
package pixel_pair_packer_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_SOF = 2'd1,
    S_FRAME    = 2'd2
  } cam_state_e;

  localparam int CAM_PIX_W  = 10;
  localparam int CAM_FCNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/pixel_pair_packer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pixel_pair_packer -- packs even/odd camera pixels into pairs, frames output
// Rev 1.0
// ---------------------------------------------------------------------------
module pixel_pair_packer
  import pixel_pair_packer_pkg::*;
#(
  parameter int PIX_W  = CAM_PIX_W,
  parameter int LCNT_W = 12,
  parameter int FCNT_W = CAM_FCNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [PIX_W-1:0]    cam_pixel,
  input  logic                cam_fv,
  input  logic                cam_lv,
  output logic [2*PIX_W-1:0]  pixel_data,
  output logic                line_valid,
  output logic                frame_valid,
  output logic                frame_done,
  output logic [FCNT_W-1:0]   frame_count,
  output logic [LCNT_W-1:0]   line_count,
  output logic                err_odd
);

  cam_state_e        state, state_nx;
  logic              fv_d, lv_d;
  logic              phase;
  logic              end_d1, end_d2;
  logic [PIX_W-1:0]  hold;
  logic [LCNT_W-1:0] line_cnt;

  logic sof, in_frame, pix_valid, line_end, frame_end;

  assign pix_valid = cam_fv & cam_lv;
  assign in_frame  = (state == S_FRAME);
  assign sof       = (state == S_WAIT_SOF) && cam_fv && !fv_d;
  assign line_end  = in_frame && lv_d && !cam_lv;
  assign frame_end = in_frame && !cam_fv;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (enable)  state_nx = S_WAIT_SOF;
      S_WAIT_SOF: if (sof)     state_nx = S_FRAME;
      S_FRAME:    if (!cam_fv) state_nx = S_IDLE;
      default:                 state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fv_d        <= 1'b0;
      lv_d        <= 1'b0;
      phase       <= 1'b0;
      end_d1      <= 1'b0;
      end_d2      <= 1'b0;
      hold        <= '0;
      line_cnt    <= '0;
      pixel_data  <= '0;
      line_valid  <= 1'b0;
      frame_valid <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      line_count  <= '0;
      err_odd     <= 1'b0;
    end else begin
      fv_d       <= cam_fv;
      lv_d       <= cam_lv;
      line_valid <= 1'b0;
      frame_done <= 1'b0;
      // Two-stage delay so frame_valid falls after the last pair's qualifier.
      end_d1     <= frame_end;
      end_d2     <= end_d1;

      if (sof) begin
        phase    <= pix_valid;
        line_cnt <= '0;
        if (pix_valid) hold <= cam_pixel;
      end else if (in_frame) begin
        frame_valid <= 1'b1;
        if (pix_valid) begin
          if (!phase) begin
            hold  <= cam_pixel;
            phase <= 1'b1;
          end else begin
            pixel_data <= {cam_pixel, hold};
            line_valid <= 1'b1;
            phase      <= 1'b0;
          end
        end else if (line_end || frame_end) begin
          // A held even pixel with no partner is discarded.
          if (phase) err_odd <= 1'b1;
          phase <= 1'b0;
        end
        if (line_end && (line_cnt != '1)) line_cnt <= line_cnt + 1'b1;
      end

      if (end_d2) begin
        frame_valid <= 1'b0;
        frame_done  <= 1'b1;
        line_count  <= line_cnt;
        frame_count <= frame_count + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/pixel_pair_packer.md
PIXEL_PAIR_PACKER -- requirements
Module: pixel_pair_packer

Interface
REQ-001 The block SHALL have parameter PIX_W, default 10, meaning camera pixel width in bits.
REQ-002 The block SHALL have parameter LCNT_W, default 12, meaning line counter width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: pixel clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port enable, input, 1 bit: arms capture; it is sampled only in IDLE.
REQ-006 The block SHALL have port cam_pixel, input, PIX_W bits: one camera pixel per clk.
REQ-007 The block SHALL have port cam_fv, input, 1 bit: camera frame valid.
REQ-008 The block SHALL have port cam_lv, input, 1 bit: camera line valid; a pixel is valid when cam_fv and cam_lv are both high.
REQ-009 The block SHALL have port pixel_data, output, 2*PIX_W bits: packed pair; [PIX_W-1:0] is the first (even) pixel and the upper half is the second (odd) pixel.
REQ-010 The block SHALL have port frame_valid, output, 1 bit: frame envelope for the downstream histogram stage.
REQ-011 The block SHALL have port line_valid, output, 1 bit: one-cycle qualifier per packed pair.
REQ-012 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse at the end of each frame.
REQ-013 The block SHALL have port frame_count, output, 16 bits: number of completed frames.
REQ-014 The block SHALL have port line_count, output, LCNT_W bits: number of lines in the last completed frame.
REQ-015 The block SHALL have port err_odd, output, 1 bit: sticky flag, set when any line had an odd pixel count.

Function
REQ-016 The state machine SHALL have three states: IDLE, WAIT_SOF and FRAME.
REQ-017 From IDLE, the block SHALL go to WAIT_SOF when enable=1.
REQ-018 From WAIT_SOF, the block SHALL go to FRAME only on a rising edge of cam_fv (previous sample 0, current sample 1), so a frame already in progress at arm time is discarded.
REQ-019 From FRAME, the block SHALL go to IDLE on the first cycle that cam_fv is sampled 0.
REQ-020 Pairing: the first valid pixel of each line SHALL be held in a register; the next valid pixel completes the pair.
REQ-021 On the cycle after the pair completes, pixel_data SHALL be updated and line_valid SHALL be 1 for exactly one clk; pairing latency is therefore 1 clk after the odd pixel is sampled.
REQ-022 The pairing phase SHALL reset to "even" on every cam_lv falling edge and on frame entry.
REQ-023 An odd trailing pixel SHALL be dropped, never emitted, and SHALL set err_odd.
REQ-024 pixel_data SHALL hold its last value when line_valid=0.
REQ-025 frame_valid SHALL rise 1 clk after the FRAME entry cycle.
REQ-026 frame_valid SHALL fall 2 clk after cam_fv is first sampled 0, so the last pair's line_valid always precedes the frame_valid fall by at least 1 clk.
REQ-027 frame_done SHALL pulse on the same cycle frame_valid falls.
REQ-028 An internal line counter SHALL increment on each cam_lv falling edge while in FRAME and SHALL saturate at all-ones.
REQ-029 line_count SHALL load the internal line counter value at frame_done.
REQ-030 frame_count SHALL increment at frame_done and SHALL wrap from 0xFFFF to 0.
REQ-031 If cam_lv is high while cam_fv is low, the pixel SHALL be ignored and no pair or count update SHALL occur.
REQ-032 If enable drops mid-frame, the current frame SHALL complete normally.
REQ-033 Simultaneous cam_lv fall and cam_fv fall SHALL count the line and then end the frame.
REQ-034 Back-to-back frames SHALL be supported: after return to IDLE with enable=1, the next cam_fv rise SHALL be captured with at least 1 idle cycle of cam_fv=0.

Reset
REQ-035 On reset, the block SHALL go to IDLE, and pixel_data, line_valid, frame_valid, frame_done, frame_count, line_count and err_odd SHALL all be 0.
REQ-036 On reset, the internal pixel hold register, phase and line counters SHALL be cleared.
REQ-037 Reset mid-frame SHALL drop frame_valid on the next clk without a frame_done pulse.
REQ-038 err_odd SHALL be cleared only by reset.

Structure
REQ-039 The state enum, PIX_W default and frame-counter width SHALL reside in the shared camera package.
REQ-040 The block SHALL be a single module with no sub-module; the edge detectors and counters are inline.

Verification
REQ-041 enable=1, one frame of 4 lines × 8 pixels with values 0..7 per line -> 4 line_valid pulses per line; the first pair has pixel_data lower half=0 and upper half=1; frame_done once; line_count=4; frame_count=1; err_odd=0.
REQ-042 A line of 5 pixels -> 2 pairs emitted; the 5th pixel is not emitted; err_odd=1 and stays 1 across the next clean frame.
REQ-043 enable asserted while cam_fv is already high -> no output for that frame; the next full frame is captured with frame_count=1.
REQ-044 reset pulsed mid-line -> all outputs 0 next clk, no frame_done pulse, and the following frame is captured cleanly.
REQ-045 cam_lv pulses while cam_fv=0 -> no line_valid pulses and no count change.
REQ-046 65536 minimal frames -> frame_count wraps to 0, and frame_valid falls ≥1 clk after the last line_valid every frame.
